input_debounce: RTL and testbench
=================================

// Module: input_debounce
// PURPOSE
//   Conditions one asynchronous external input (switch/button) into a clean,
//   synchronous level for the register stage that consumes it. Synchronises
//   raw_i into clk, rejects pulses shorter than DEBOUNCE_CYCLES, and emits
//   one-cycle rise/fall pulses. d_o connects directly to the downstream flop's d_i.
// PARAMETERS
//   SYNC_STAGES      2  synchroniser flop count; legal >= 2
//   DEBOUNCE_CYCLES  4  consecutive differing samples needed to accept a new level; legal >= 1
//   RST_VAL          0  reset value of synchroniser flops and d_o
// PORTS
//   clk     in   1  single clock; all logic on rising edge
//   rst_n   in   1  reset, asynchronous, active-low; async assert, release on clk
//   raw_i   in   1  asynchronous raw input, may bounce
//   d_o     out  1  debounced, synchronous level
//   rise_o  out  1  one-cycle pulse, d_o went 0->1
//   fall_o  out  1  one-cycle pulse, d_o went 1->0
//   busy_o  out  1  high while a candidate level change is being counted
// BEHAVIOUR
//   - Reset (rst_n=0): immediately, without a clock edge: sync chain = RST_VAL,
//     d_o = RST_VAL, rise_o = fall_o = 0, busy_o = 0, cnt = 0, state = STABLE.
//   - Sync chain: s[0] <= raw_i, s[k] <= s[k-1]; sample = s[SYNC_STAGES-1].
//     No logic other than the chain reads raw_i or s[0..SYNC_STAGES-2].
//   - cnt width = $clog2(DEBOUNCE_CYCLES+1); cnt never exceeds DEBOUNCE_CYCLES.
//   - FSM, 2 states, evaluated each rising edge:
//     STABLE:   sample == d_o -> stay, cnt = 0.
//               sample != d_o, DEBOUNCE_CYCLES == 1 -> d_o <= sample, stay.
//               sample != d_o, otherwise -> COUNTING, cnt <= 1.
//     COUNTING: sample == d_o -> STABLE, cnt <= 0 (glitch rejected, no pulse).
//               sample != d_o, cnt == DEBOUNCE_CYCLES-1 -> d_o <= sample,
//               STABLE, cnt <= 0.
//               sample != d_o, otherwise -> cnt <= cnt + 1.
//   - busy_o = (state == COUNTING), combinational from state register.
//   - rise_o/fall_o registered: high in exactly the cycle d_o first shows its
//     new value, low the next cycle. Never both high. Never high out of reset.
//   - Latency: raw_i changes (setup met) before edge 1 and holds -> d_o changes
//     on edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: edge 6).
//   - Glitch: new level held at sample for < DEBOUNCE_CYCLES consecutive
//     cycles -> d_o unchanged, no pulse, busy_o returns 0.
//   - Bounce during COUNTING: any return of sample to d_o restarts from zero;
//     counts are never accumulated across interruptions.
//   - Reset mid-count or with d_o=1: all state cleared asynchronously; d_o
//     drop caused by reset produces no fall_o.
//   - After reset release, raw_i != RST_VAL is debounced as a normal change
//     (produces rise_o/fall_o after full latency).
// TESTING
//   1. rst_n=0, raw_i=1, between edges -> d_o=0, rise_o=fall_o=busy_o=0 immediately.
//   2. Defaults, raw_i 0->1 before edge 1, held -> busy_o high after edges 3..5,
//      d_o=1 and rise_o=1 after edge 6, rise_o=0 after edge 7.
//   3. Defaults, raw_i high for 3 cycles then low -> d_o stays 0, no rise_o,
//      busy_o returns 0.
//   4. From d_o=1, raw_i 1->0 with bounce 0,1,0 then held 0 -> single fall_o,
//      d_o=0 only after 4 consecutive 0 samples.
//   5. Defaults, rst_n=0 while busy_o=1, release with raw_i=1 -> outputs cleared
//      at once; rise_o exactly 6 edges after release edge.
//   6. SYNC_STAGES=3, DEBOUNCE_CYCLES=1: raw_i 0->1 -> d_o=1, rise_o=1 on edge 4,
//      busy_o never asserts.

Source files
------------

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - synchroniser, debounce filter and edge pulses for one raw input
module input_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic d_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [0:0]      ST_STABLE   = 1'b0;
  localparam logic [0:0]      ST_COUNTING = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic [0:0]             state;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];
  assign busy_o = (state == ST_COUNTING);

  // A candidate level must be seen DEBOUNCE_CYCLES times in a row; any
  // return to the current level throws the partial count away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_STABLE;
      cnt    <= '0;
      d_o    <= RST_VAL;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      case (state)
        ST_STABLE: begin
          cnt <= '0;
          if (sample != d_o) begin
            if (DEBOUNCE_CYCLES == 1) begin
              d_o    <= sample;
              rise_o <= sample;
              fall_o <= ~sample;
            end else begin
              state <= ST_COUNTING;
              cnt   <= CW'(1);
            end
          end
        end
        default: begin
          if (sample == d_o) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            d_o    <= sample;
            rise_o <= sample;
            fall_o <= ~sample;
            state  <= ST_STABLE;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_debounce.sv
// tb/tb_input_debounce.sv - directed-vector bench for input_debounce
module tb_input_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic raw = 1'b0;
  logic d, rise, fall, busy;
  logic raw6 = 1'b0;
  logic d6, rise6, fall6, busy6;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  input_debounce dut (
    .clk(clk), .rst_n(rst_n), .raw_i(raw),
    .d_o(d), .rise_o(rise), .fall_o(fall), .busy_o(busy)
  );

  input_debounce #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RST_VAL(1'b0)) dut6 (
    .clk(clk), .rst_n(rst_n), .raw_i(raw6),
    .d_o(d6), .rise_o(rise6), .fall_o(fall6), .busy_o(busy6)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Bit i of each vector: raw applied before edge i+1, outputs expected after it.
  task automatic run_vec(input string tag, input int n, input logic [0:15] rv,
                         input logic [0:15] dv, input logic [0:15] rsv,
                         input logic [0:15] fv, input logic [0:15] bv);
    for (int i = 0; i < n; i++) begin
      raw = rv[i];
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s d e%0d", tag, i + 1), d, dv[i]);
      check($sformatf("%s rise e%0d", tag, i + 1), rise, rsv[i]);
      check($sformatf("%s fall e%0d", tag, i + 1), fall, fv[i]);
      check($sformatf("%s busy e%0d", tag, i + 1), busy, bv[i]);
    end
  endtask

  initial begin
    // Reset asserted between edges with raw high: outputs clear at once.
    raw = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst d", d, 1'b0);
    check("rst rise", rise, 1'b0);
    check("rst fall", fall, 1'b0);
    check("rst busy", busy, 1'b0);
    raw = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end

    // Clean rise: d after edge 6, busy after edges 3..5.
    run_vec("rise", 8, 16'b1111_1111_0000_0000, 16'b0000_0111_0000_0000,
            16'b0000_0100_0000_0000, 16'h0000, 16'b0011_1000_0000_0000);

    // Bounce 0,1,0 then held 0: single fall after edge 8.
    run_vec("bounce", 10, 16'b0100_0000_0000_0000, 16'b1111_1110_0000_0000,
            16'h0000, 16'b0000_0001_0000_0000, 16'b0010_1110_0000_0000);

    // Three-cycle high glitch is rejected.
    run_vec("glitch", 8, 16'b1110_0000_0000_0000, 16'h0000,
            16'h0000, 16'h0000, 16'b0011_1000_0000_0000);

    // Interrupted count restarts from zero: d only after edge 10.
    run_vec("restart", 12, 16'b1110_1111_1111_0000, 16'b0000_0000_0111_0000,
            16'b0000_0000_0100_0000, 16'h0000, 16'b0011_1011_1000_0000);

    // Reset while counting from d=1, release with raw high.
    run_vec("precnt", 4, 16'h0000, 16'b1111_0000_0000_0000,
            16'h0000, 16'h0000, 16'b0011_0000_0000_0000);
    raw = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid rst d", d, 1'b0);
    check("mid rst fall", fall, 1'b0);
    check("mid rst busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("mid rst hold fall", fall, 1'b0);
    rst_n = 1'b1;
    run_vec("post rst", 8, 16'b1111_1111_0000_0000, 16'b0000_0111_0000_0000,
            16'b0000_0100_0000_0000, 16'h0000, 16'b0011_1000_0000_0000);

    // SYNC_STAGES=3, DEBOUNCE_CYCLES=1: d and rise after edge 4, never busy.
    raw6 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("s3d1 d e%0d", i), d6, (i >= 4) ? 1'b1 : 1'b0);
      check($sformatf("s3d1 rise e%0d", i), rise6, (i == 4) ? 1'b1 : 1'b0);
      check($sformatf("s3d1 fall e%0d", i), fall6, 1'b0);
      check($sformatf("s3d1 busy e%0d", i), busy6, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
